fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_redirect_sel.sv | 38 +++
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional misaligned-fetch trap is enabled by defining FETCH_ALIGN_CHK_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect arbiter: eret > cp0 exception > jump > branch.
// Branch and jump come from the pipeline and are meaningless while IF/ID is held.
module fetch_redirect_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        cp0_req,
    input  logic        eret,
    input  logic [31:0] pc_branch,
    input  logic [31:0] pc_jump,
    input  logic [31:0] epc,
    output logic        valid,
    output logic [31:0] target
);

    always_comb begin
        valid  = 1'b0;
        target = '0;
        if (eret) begin
            valid  = 1'b1;
            target = epc;
        end else if (cp0_req) begin
            valid  = 1'b1;
            target = EXC_VECTOR;
        end else if (jump && !stall) begin
            valid  = 1'b1;
            target = pc_jump;
        end else if (branch && !stall) begin
            valid  = 1'b1;
            target = pc_branch;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect/kill handling.
// Defining FETCH_ALIGN_CHK_EN adds if_adel and traps misaligned fetch addresses.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        cp0_req,
    input  logic        eret,
    input  logic [31:0] pc_branch,
    input  logic [31:0] pc_jump,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        busy
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        if_adel
`endif
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  pending;
    logic         kill;

    logic         redir_valid;
    logic [31:0]  redir_target;
    logic         launch;
    logic [31:0]  launch_pc;

    fetch_redirect_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_sel (
        .stall     (stall),
        .branch    (branch),
        .jump      (jump),
        .cp0_req   (cp0_req),
        .eret      (eret),
        .pc_branch (pc_branch),
        .pc_jump   (pc_jump),
        .epc       (epc),
        .valid     (redir_valid),
        .target    (redir_target)
    );

    // Every path that starts a new fetch funnels through launch/launch_pc,
    // so the REQ entry (and the alignment trap) is handled in one place.
    always_comb begin
        launch    = 1'b0;
        launch_pc = fetch_pc;
        case (state)
            IDLE: launch = 1'b1;
            REQ: begin
                if (redir_valid && !imem_gnt) begin
                    launch    = 1'b1;
                    launch_pc = redir_target;
                end
            end
            WAIT: begin
                if (imem_rvalid && (kill || redir_valid)) begin
                    launch    = 1'b1;
                    launch_pc = redir_valid ? redir_target : pending;
                end
            end
            DONE: begin
                if (redir_valid) begin
                    launch    = 1'b1;
                    launch_pc = redir_target;
                end else if (!stall) begin
                    launch    = 1'b1;
                    launch_pc = fetch_pc + 32'd4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            pending   <= RESET_PC;
            kill      <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            instr     <= '0;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            busy      <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            if_adel   <= 1'b0;
`endif
        end else if (launch) begin
            fetch_pc <= launch_pc;
            kill     <= 1'b0;
            if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            if_adel  <= 1'b0;
            if (misaligned(launch_pc)) begin
                state    <= DONE;
                imem_req <= 1'b0;
                busy     <= 1'b0;
                instr    <= NOP_WORD;
                pc       <= launch_pc;
                if_valid <= 1'b1;
                if_adel  <= 1'b1;
            end else
`endif
            begin
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= launch_pc;
                busy      <= 1'b1;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        if (redir_valid) begin
                            kill    <= 1'b1;
                            pending <= redir_target;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        instr    <= imem_rdata;
                        pc       <= fetch_pc;
                        if_valid <= 1'b1;
                    end else if (redir_valid) begin
                        kill    <= 1'b1;
                        pending <= redir_target;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl; delivered words are checked against a scoreboard.
// Build with FETCH_ALIGN_CHK_EN defined to also exercise the misaligned-fetch trap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        cp0_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] pc_branch = '0;
    logic [31:0] pc_jump = '0;
    logic [31:0] epc = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        if_valid;
    logic        busy;
`ifdef FETCH_ALIGN_CHK_EN
    logic        if_adel;
`endif

    int passed = 0;
    int total = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_word;
    logic        prev_valid = 1'b0;

    fetch_ctrl #(
        .RESET_PC   (32'h0000_3000),
        .EXC_VECTOR (32'h0000_4180)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .cp0_req     (cp0_req),
        .eret        (eret),
        .pc_branch   (pc_branch),
        .pc_jump     (pc_jump),
        .epc         (epc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc          (pc),
        .if_valid    (if_valid),
        .busy        (busy)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .if_adel     (if_adel)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    // Each new word presented to IF/ID must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && if_valid && !prev_valid) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", pc, instr);
            end else begin
                exp_word = sb.pop_front();
                if (pc !== exp_word[63:32] || instr !== exp_word[31:0])
                    $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                             pc, instr, exp_word[63:32], exp_word[31:0]);
                else
                    passed++;
            end
        end
        prev_valid = if_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [31:0] exp_pc, input logic [31:0] data, input int lat);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        repeat (lat - 1) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back({exp_pc, data});
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b required 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h3000) $display("FAIL rst_addr: got %h required 00003000", imem_addr); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h required 0", instr); else passed++;
        total++; if (pc !== 32'h3000) $display("FAIL rst_pc: got %h required 00003000", pc); else passed++;
        total++; if (if_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_flags: got valid=%b busy=%b required 0 0", if_valid, busy); else passed++;
        reset = 1'b1;
        total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b required 0", imem_req); else passed++;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || busy !== 1'b1)
            $display("FAIL first_req: got req=%b addr=%h busy=%b required 1 00003000 1", imem_req, imem_addr, busy);
        else passed++;
    endtask

    task automatic test_basic();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        total++; if (imem_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL wait_req: got req=%b busy=%b required 0 1", imem_req, busy); else passed++;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2402_0001;
        sb.push_back({32'h0000_3000, 32'h2402_0001});
        tick();
        imem_rvalid = 1'b0;
        total++; if (if_valid !== 1'b1 || busy !== 1'b0 || instr !== 32'h2402_0001 || pc !== 32'h3000)
            $display("FAIL basic_done: got v=%b busy=%b instr=%h pc=%h required 1 0 24020001 00003000",
                     if_valid, busy, instr, pc);
        else passed++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        branch = 1'b1;
        pc_branch = 32'h3100;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if_valid !== 1'b1 || instr !== 32'h2402_0001 || pc !== 32'h3000 || imem_req !== 1'b0)
                $display("FAIL stall_hold: cycle %0d got v=%b instr=%h pc=%h req=%b required 1 24020001 00003000 0",
                         i, if_valid, instr, pc, imem_req);
            else passed++;
        end
        stall = 1'b0;
        branch = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || if_valid !== 1'b0)
            $display("FAIL stall_next: got req=%b addr=%h v=%b required 1 00003004 0", imem_req, imem_addr, if_valid);
        else passed++;
    endtask

    task automatic test_kill();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        jump = 1'b1;
        pc_jump = 32'h3200;
        tick();
        jump = 1'b0;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3200)
            $display("FAIL kill_redirect: got v=%b req=%b addr=%h required 0 1 00003200", if_valid, imem_req, imem_addr);
        else passed++;
        // Redirect arriving together with the response discards it too.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0001;
        branch = 1'b1;
        pc_branch = 32'h3300;
        tick();
        imem_rvalid = 1'b0;
        branch = 1'b0;
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h3300)
            $display("FAIL kill_same_cycle: got v=%b addr=%h required 0 00003300", if_valid, imem_addr);
        else passed++;
        serve(32'h3300, 32'h1111_2222, 2);
    endtask

    task automatic test_eret();
        stall = 1'b1;
        eret = 1'b1;
        epc = 32'h3050;
        cp0_req = 1'b1;
        tick();
        eret = 1'b0;
        cp0_req = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3050 || if_valid !== 1'b0)
            $display("FAIL eret_prio: got req=%b addr=%h v=%b required 1 00003050 0", imem_req, imem_addr, if_valid);
        else passed++;
        stall = 1'b0;
        serve(32'h3050, 32'h3333_4444, 1);
    endtask

    task automatic test_cp0_reset();
        tick();
        total++; if (imem_addr !== 32'h3054) $display("FAIL seq_after_eret: got %h required 00003054", imem_addr); else passed++;
        jump = 1'b1; pc_jump = 32'h3400;
        branch = 1'b1; pc_branch = 32'h3500;
        tick();
        total++; if (imem_addr !== 32'h3400) $display("FAIL jump_over_branch: got %h required 00003400", imem_addr); else passed++;
        cp0_req = 1'b1;
        tick();
        cp0_req = 1'b0; jump = 1'b0; branch = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4180)
            $display("FAIL cp0_req_nogt: got req=%b addr=%h required 1 00004180", imem_req, imem_addr); else passed++;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h3000 || instr !== 32'h0 || pc !== 32'h3000 ||
                     if_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL async_reset: got req=%b addr=%h instr=%h pc=%h v=%b busy=%b required reset values",
                     imem_req, imem_addr, instr, pc, if_valid, busy);
        else passed++;
        tick();
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_0002;
        tick();
        imem_rvalid = 1'b0;
        total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000)
            $display("FAIL idle_ignore: got v=%b req=%b addr=%h required 0 1 00003000", if_valid, imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h3000 + 32'(4 * i);
            total++; if (imem_addr !== addr) $display("FAIL b2b_addr: got %h required %h", imem_addr, addr); else passed++;
            serve(addr, $urandom, int'($urandom_range(1, 3)));
            tick();
        end
        jump = 1'b1;
        pc_jump = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_jump: got %h required fffffffc", imem_addr); else passed++;
        serve(32'hFFFF_FFFC, 32'h5555_6666, 2);
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL wrap_addr: got req=%b addr=%h required 1 00000000", imem_req, imem_addr); else passed++;
    endtask

`ifdef FETCH_ALIGN_CHK_EN
    task automatic test_align();
        jump = 1'b1;
        pc_jump = 32'h3002;
        sb.push_back({32'h0000_3002, 32'h0});
        tick();
        jump = 1'b0;
        total++; if (imem_req !== 1'b0 || if_adel !== 1'b1 || instr !== 32'h0 || pc !== 32'h3002 || if_valid !== 1'b1)
            $display("FAIL align_trap: got req=%b adel=%b instr=%h pc=%h v=%b required 0 1 0 00003002 1",
                     imem_req, if_adel, instr, pc, if_valid);
        else passed++;
        jump = 1'b1;
        pc_jump = 32'h3100;
        tick();
        jump = 1'b0;
        total++; if (if_adel !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3100)
            $display("FAIL align_clear: got adel=%b req=%b addr=%h required 0 1 00003100", if_adel, imem_req, imem_addr);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_kill();
        test_eret();
        test_cp0_reset();
        test_back_to_back();
`ifdef FETCH_ALIGN_CHK_EN
        test_align();
`endif
        repeat (2) tick();
        total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending words required 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
